// File: rtl/alu_wb_stage.sv
// alu_wb_stage: 2-entry skid buffer retiring ALU results to the register file, with flags and forwarding
module alu_wb_stage #(
  parameter int DEPTH = 2,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   alu_out,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_v,
  input  logic [2:0]    opcode,
  input  logic [AW-1:0] dest,
  input  logic          wb_en,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [15:0]   rf_wdata,
  input  logic          rf_ready,
  input  logic          flush,
  input  logic [AW-1:0] fwd_raddr,
  output logic          fwd_hit,
  output logic [15:0]   fwd_data,
  output logic          flag_n,
  output logic          flag_z,
  output logic          flag_v
);
  logic [1:0]       count_q, count_d;
  logic             head_q, head_d, tail_q, tail_d;
  logic             flag_n_q, flag_n_d, flag_z_q, flag_z_d, flag_v_q, flag_v_d;
  logic [15:0]      data_q [DEPTH];
  logic [15:0]      data_d [DEPTH];
  logic [2:0]       op_q [DEPTH];
  logic [2:0]       op_d [DEPTH];
  logic [AW-1:0]    dest_q [DEPTH];
  logic [AW-1:0]    dest_d [DEPTH];
  logic [DEPTH-1:0] n_q, n_d, z_q, z_d, v_q, v_d, wb_q, wb_d;
  logic             has, accept, commit, yng, hit_y, hit_o;
  assign in_ready = count_q != 2'd2;
  assign has      = count_q != 2'd0;
  assign rf_we    = has && wb_q[head_q];
  assign rf_waddr = dest_q[head_q];
  assign rf_wdata = data_q[head_q];
  assign accept   = in_valid && in_ready && !flush;
  assign commit   = has && (!wb_q[head_q] || rf_ready) && !flush;
  // When full, the younger entry is the one after the head.
  assign yng      = ~head_q;
  assign hit_y    = count_q == 2'd2 && wb_q[yng] && dest_q[yng] == fwd_raddr;
  assign hit_o    = has && wb_q[head_q] && dest_q[head_q] == fwd_raddr;
  assign fwd_hit  = hit_y || hit_o;
  assign fwd_data = hit_y ? data_q[yng] : hit_o ? data_q[head_q] : 16'h0;
  assign flag_n   = flag_n_q;
  assign flag_z   = flag_z_q;
  assign flag_v   = flag_v_q;
  always_comb begin
    count_d  = flush ? 2'd0 : count_q + 2'(accept) - 2'(commit);
    head_d   = flush ? 1'b0 : head_q ^ commit;
    tail_d   = flush ? 1'b0 : tail_q ^ accept;
    flag_n_d = commit ? n_q[head_q] : flag_n_q;
    flag_z_d = commit ? z_q[head_q] : flag_z_q;
    flag_v_d = commit && (op_q[head_q] == 3'd0 || op_q[head_q] == 3'd2) ? v_q[head_q] : flag_v_q;
    data_d   = data_q;
    op_d     = op_q;
    dest_d   = dest_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    wb_d     = wb_q;
    if (accept) begin
      data_d[tail_q] = alu_out;
      op_d[tail_q]   = opcode;
      dest_d[tail_q] = dest;
      n_d[tail_q]    = alu_n;
      z_d[tail_q]    = alu_z;
      v_d[tail_q]    = alu_v;
      wb_d[tail_q]   = wb_en;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
    end
  end
  always_ff @(posedge clk) begin
    data_q <= data_d;
    op_q   <= op_d;
    dest_q <= dest_d;
    n_q    <= n_d;
    z_q    <= z_d;
    v_q    <= v_d;
    wb_q   <= wb_d;
  end
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: vector table plus queue scoreboard for the writeback stage
module tb_alu_wb_stage;
  typedef struct packed {
    logic [15:0] d;
    logic        n, z, v;
    logic [2:0]  op;
    logic [3:0]  dest;
    logic        wb;
  } beat_t;
  typedef struct {
    beat_t       b;
    logic        rdy;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [15:0] exp_data;
    logic [2:0]  exp_flags;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready;
  logic [15:0] alu_out = 0;
  logic alu_n = 0, alu_z = 0, alu_v = 0, wb_en = 0;
  logic [2:0] opcode = 0;
  logic [3:0] dest = 0, rf_waddr, fwd_raddr = 0;
  logic rf_we, rf_ready = 0, flush = 0, fwd_hit, flag_n, flag_z, flag_v;
  logic [15:0] rf_wdata, fwd_data;
  int tests = 0, fails = 0;
  beat_t q[$];
  logic [2:0] mf = 0;
  logic [2:0] fs;
  vec_t vt[10];
  alu_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .opcode(opcode), .dest(dest), .wb_en(wb_en), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flush(flush), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic set_beat(input beat_t b);
    {alu_out, alu_n, alu_z, alu_v, opcode, dest, wb_en} = b;
  endtask
  // Compare against the queue model, advance the model, then take one clock.
  task automatic cyc();
    beat_t cur, h;
    logic acc, com, hit;
    logic [15:0] fd;
    #1;
    if (rst_n) begin
      hit = 0;
      fd = 0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (!hit && q[i].wb && q[i].dest == fwd_raddr) begin
          hit = 1;
          fd = q[i].d;
        end
      chk("in_ready", in_ready, q.size() != 2);
      chk("rf_we", rf_we, q.size() != 0 && q[0].wb);
      if (q.size() != 0 && q[0].wb) begin
        chk("rf_waddr", rf_waddr, q[0].dest);
        chk("rf_wdata", rf_wdata, q[0].d);
      end
      chk("fwd_hit", fwd_hit, hit);
      chk("fwd_data", fwd_data, fd);
      chk("flags", {flag_n, flag_z, flag_v}, mf);
    end
    cur = {alu_out, alu_n, alu_z, alu_v, opcode, dest, wb_en};
    if (!rst_n) begin
      q.delete();
      mf = 0;
    end else if (flush) q.delete();
    else begin
      acc = in_valid && q.size() != 2;
      com = q.size() != 0 && (!q[0].wb || rf_ready);
      if (com) begin
        h = q.pop_front();
        mf[2] = h.n;
        mf[1] = h.z;
        if (h.op == 3'd0 || h.op == 3'd2) mf[0] = h.v;
      end
      if (acc) q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input beat_t b);
    set_beat(b);
    in_valid = 1;
    cyc();
    in_valid = 0;
  endtask
  initial begin
    vt[0] = '{{16'h8000, 3'b101, 3'd0, 4'd3,  1'b1}, 1'b1, 1'b1, 4'd3,  16'h8000, 3'b101};
    vt[1] = '{{16'h0000, 3'b010, 3'd4, 4'd4,  1'b1}, 1'b1, 1'b1, 4'd4,  16'h0000, 3'b011};
    vt[2] = '{{16'h0001, 3'b000, 3'd2, 4'd6,  1'b1}, 1'b1, 1'b1, 4'd6,  16'h0001, 3'b000};
    vt[3] = '{{16'h7ffe, 3'b001, 3'd5, 4'd7,  1'b1}, 1'b1, 1'b1, 4'd7,  16'h7ffe, 3'b000};
    vt[4] = '{{16'hff00, 3'b101, 3'd1, 4'd8,  1'b1}, 1'b1, 1'b1, 4'd8,  16'hff00, 3'b100};
    vt[5] = '{{16'h8000, 3'b101, 3'd2, 4'd15, 1'b1}, 1'b1, 1'b1, 4'd15, 16'h8000, 3'b101};
    vt[6] = '{{16'hffff, 3'b100, 3'd3, 4'd0,  1'b1}, 1'b1, 1'b1, 4'd0,  16'hffff, 3'b101};
    vt[7] = '{{16'h0000, 3'b010, 3'd6, 4'd9,  1'b1}, 1'b1, 1'b1, 4'd9,  16'h0000, 3'b011};
    vt[8] = '{{16'hffff, 3'b100, 3'd7, 4'd2,  1'b0}, 1'b0, 1'b0, 4'd0,  16'h0000, 3'b101};
    vt[9] = '{{16'h0000, 3'b010, 3'd0, 4'd1,  1'b0}, 1'b0, 1'b0, 4'd0,  16'h0000, 3'b010};
    cyc();
    cyc();
    rst_n = 1;
    chk("rst in_ready", in_ready, 1);
    chk("rst rf_we", rf_we, 0);
    chk("rst fwd_hit", fwd_hit, 0);
    chk("rst flags", {flag_n, flag_z, flag_v}, 3'b000);
    for (int i = 0; i < 10; i++) begin
      rf_ready = vt[i].rdy;
      send(vt[i].b);
      chk("vec rf_we", rf_we, vt[i].exp_we);
      if (vt[i].exp_we) begin
        chk("vec rf_waddr", rf_waddr, vt[i].exp_addr);
        chk("vec rf_wdata", rf_wdata, vt[i].exp_data);
      end
      cyc();
      chk("vec flags", {flag_n, flag_z, flag_v}, vt[i].exp_flags);
      chk("vec retired", {in_ready, rf_we}, 2'b10);
    end
    rf_ready = 0;
    send({16'h1111, 3'b000, 3'd0, 4'd1, 1'b1});
    chk("bp ready after 1", in_ready, 1);
    send({16'h2222, 3'b101, 3'd0, 4'd2, 1'b1});
    chk("bp ready full", in_ready, 0);
    set_beat({16'h3333, 3'b000, 3'd0, 4'd3, 1'b1});
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("bp stable waddr", rf_waddr, 1);
    chk("bp stable wdata", rf_wdata, 16'h1111);
    chk("bp ready held", in_ready, 0);
    rf_ready = 1;
    cyc();
    chk("bp ready back", in_ready, 1);
    chk("bp second wdata", rf_wdata, 16'h2222);
    cyc();
    chk("bp drained", rf_we, 0);
    chk("bp flags", {flag_n, flag_z, flag_v}, 3'b101);
    for (int i = 0; i < 4; i++) begin
      set_beat({16'(16'h0100 * i + i), 3'(i), 3'(i), 4'(i + 10), 1'b1});
      in_valid = 1;
      cyc();
    end
    in_valid = 0;
    cyc();
    cyc();
    rf_ready = 0;
    send({16'h00aa, 3'b000, 3'd0, 4'd5, 1'b1});
    send({16'h00bb, 3'b000, 3'd0, 4'd5, 1'b1});
    fwd_raddr = 5;
    #1;
    chk("fwd young hit", fwd_hit, 1);
    chk("fwd young data", fwd_data, 16'h00bb);
    fwd_raddr = 6;
    #1;
    chk("fwd miss hit", fwd_hit, 0);
    chk("fwd miss data", fwd_data, 0);
    fwd_raddr = 5;
    fs = mf;
    set_beat({16'h9999, 3'b010, 3'd0, 4'd9, 1'b1});
    in_valid = 1;
    flush = 1;
    cyc();
    flush = 0;
    in_valid = 0;
    chk("flush rf_we", rf_we, 0);
    chk("flush in_ready", in_ready, 1);
    chk("flush fwd_hit", fwd_hit, 0);
    chk("flush flags", {flag_n, flag_z, flag_v}, fs);
    cyc();
    send({16'h4444, 3'b101, 3'd0, 4'd4, 1'b1});
    send({16'h5555, 3'b101, 3'd0, 4'd5, 1'b1});
    rf_ready = 1;
    send({16'h6666, 3'b010, 3'd0, 4'd6, 1'b1});
    rf_ready = 0;
    send({16'h7777, 3'b010, 3'd0, 4'd7, 1'b1});
    set_beat({16'h8888, 3'b111, 3'd0, 4'd8, 1'b1});
    in_valid = 1;
    rst_n = 0;
    cyc();
    rst_n = 1;
    in_valid = 0;
    chk("reset flags", {flag_n, flag_z, flag_v}, 3'b000);
    chk("reset rf_we", rf_we, 0);
    chk("reset in_ready", in_ready, 1);
    for (int i = 0; i < 400; i++) begin
      set_beat({16'($urandom), 3'($urandom), 3'($urandom), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)});
      in_valid = 1'($urandom);
      rf_ready = 1'($urandom);
      flush = $urandom_range(0, 15) == 0;
      rst_n = $urandom_range(0, 63) != 0;
      fwd_raddr = 4'($urandom_range(0, 3));
      cyc();
    end
    flush = 0;
    rst_n = 1;
    in_valid = 0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
